// File: rtl/score_bcd_counter.sv
// Game score keeper: packed-BCD point counter paced by the game tick, with a
// session high score and a registered single-digit readout port.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | after reset; score held at 0, waiting for game_start
// S_RUNNING | run active; game ticks accumulate points
// S_OVER    | run ended; score frozen, high score already updated
module score_bcd_counter #(
    parameter int TICKS_PER_POINT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_start,
    input  logic        game_over,
    input  logic        game_tick,
    input  logic [1:0]  i_digit_sel,
    input  logic        i_sel_hi,
    output logic [15:0] o_score,
    output logic [15:0] o_hi_score,
    output logic [3:0]  o_digit,
    output logic        o_running,
    output logic        o_new_record
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUNNING,
        S_OVER
    } state_t;

    localparam logic [5:0] PRE_LAST = 6'(TICKS_PER_POINT - 1);

    state_t      state, state_nxt;
    logic [15:0] score, score_nxt;
    logic [15:0] hi_score, hi_nxt;
    logic [15:0] readout_src;
    logic [5:0]  prescaler, pre_nxt;
    logic        new_record, rec_nxt;
    logic [3:0]  digit, digit_nxt;

    // Ripple the carry digit by digit; 9999 saturates instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (v[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            score      <= 16'h0000;
            hi_score   <= 16'h0000;
            prescaler  <= 6'd0;
            new_record <= 1'b0;
            digit      <= 4'd0;
        end else begin
            state      <= state_nxt;
            score      <= score_nxt;
            hi_score   <= hi_nxt;
            prescaler  <= pre_nxt;
            new_record <= rec_nxt;
            digit      <= digit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        score_nxt = score;
        hi_nxt    = hi_score;
        pre_nxt   = prescaler;
        rec_nxt   = new_record;
        case (state)
            S_IDLE: begin
                score_nxt = 16'h0000;
                if (game_start) begin
                    state_nxt = S_RUNNING;
                    pre_nxt   = 6'd0;
                end
            end
            S_RUNNING: begin
                // game_over takes priority over a restart or a tick in the same cycle
                if (game_over) begin
                    state_nxt = S_OVER;
                    if (score > hi_score) begin
                        hi_nxt  = score;
                        rec_nxt = 1'b1;
                    end
                end else if (game_start) begin
                    score_nxt = 16'h0000;
                    pre_nxt   = 6'd0;
                end else if (game_tick) begin
                    if (prescaler == PRE_LAST) begin
                        pre_nxt   = 6'd0;
                        score_nxt = bcd_inc(score);
                    end else begin
                        pre_nxt = prescaler + 6'd1;
                    end
                end
            end
            S_OVER: begin
                if (game_start) begin
                    state_nxt = S_RUNNING;
                    score_nxt = 16'h0000;
                    pre_nxt   = 6'd0;
                    rec_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                score_nxt = 16'h0000;
                pre_nxt   = 6'd0;
            end
        endcase
    end

    always_comb begin
        readout_src = i_sel_hi ? hi_score : score;
        digit_nxt   = readout_src[{i_digit_sel, 2'b00} +: 4];
    end

    assign o_score      = score;
    assign o_hi_score   = hi_score;
    assign o_digit      = digit;
    assign o_running    = (state == S_RUNNING);
    assign o_new_record = new_record;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: a decimal reference model predicts each cycle's
// outputs into a queue, and a monitor pops and compares after every clock edge.
module tb_score_bcd_counter;

    localparam int TPP = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_start = 1'b0;
    logic        game_over = 1'b0;
    logic        game_tick = 1'b0;
    logic [1:0]  i_digit_sel = 2'd0;
    logic        i_sel_hi = 1'b0;
    logic [15:0] o_score;
    logic [15:0] o_hi_score;
    logic [3:0]  o_digit;
    logic        o_running;
    logic        o_new_record;

    score_bcd_counter #(.TICKS_PER_POINT(TPP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .game_start   (game_start),
        .game_over    (game_over),
        .game_tick    (game_tick),
        .i_digit_sel  (i_digit_sel),
        .i_sel_hi     (i_sel_hi),
        .o_score      (o_score),
        .o_hi_score   (o_hi_score),
        .o_digit      (o_digit),
        .o_running    (o_running),
        .o_new_record (o_new_record)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] score;
        logic [15:0] hi;
        logic [3:0]  digit;
        logic        running;
        logic        rec;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: plain decimal integers and a mode number
    // (0 = idle, 1 = running, 2 = over).
    int m_mode = 0;
    int m_score = 0;
    int m_hi = 0;
    int m_ticks = 0;
    int m_rec = 0;
    int m_digit = 0;
    int p10[4] = '{1, 10, 100, 1000};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic ov, input logic tk,
                        input logic [1:0] sel, input logic shi);
        int   src;
        exp_t e;
        @(negedge clk);
        rst_n = rst; game_start = st; game_over = ov; game_tick = tk;
        i_digit_sel = sel; i_sel_hi = shi;
        src = shi ? m_hi : m_score;
        m_digit = (src / p10[sel]) % 10;
        if (!rst) begin
            m_mode = 0; m_score = 0; m_hi = 0; m_ticks = 0; m_rec = 0; m_digit = 0;
        end else if (m_mode == 1) begin
            if (ov) begin
                m_mode = 2;
                if (m_score > m_hi) begin
                    m_hi = m_score;
                    m_rec = 1;
                end
            end else if (st) begin
                m_score = 0; m_ticks = 0;
            end else if (tk) begin
                m_ticks = (m_ticks + 1) % TPP;
                if (m_ticks == 0 && m_score < 9999) m_score = m_score + 1;
            end
        end else if (st) begin
            if (m_mode == 2) m_rec = 0;
            m_mode = 1; m_score = 0; m_ticks = 0;
        end
        e.score = to_bcd(m_score);
        e.hi = to_bcd(m_hi);
        e.digit = 4'(m_digit);
        e.running = (m_mode == 1);
        e.rec = (m_rec != 0);
        exp_q.push_back(e);
    endtask

    task automatic idle_cycle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    task automatic tick_cycles(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    task automatic start_run();
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic end_run();
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    // Monitor: every edge with a pending prediction gets compared field by field.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("score", o_score, e.score);
                check("hi_score", o_hi_score, e.hi);
                check("digit", {12'd0, o_digit}, {12'd0, e.digit});
                check("running", {15'd0, o_running}, {15'd0, e.running});
                check("new_record", {15'd0, o_new_record}, {15'd0, e.rec});
            end
        end
    end

    initial begin
        // Reset held for two cycles with random inputs, then ticks in idle
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        tick_cycles(20);
        end_run();

        // Counting to 0010, then a run ending at 0123 with a new record
        start_run();
        tick_cycles(60);
        idle_cycle();
        tick_cycles((123 - 10) * TPP);
        end_run();
        idle_cycle();

        // Second run ends lower; record flag drops at the start
        start_run();
        tick_cycles(45 * TPP);
        end_run();
        idle_cycle();

        // Run to 4721 for the readout sweep, then on to saturation
        start_run();
        tick_cycles(4721 * TPP);
        for (int h = 0; h < 2; h++)
            for (int d = 0; d < 4; d++)
                step(1'b1, 1'b0, 1'b0, 1'b0, 2'(d), 1'(h));
        tick_cycles((9999 - 4721) * TPP + 12);
        end_run();
        for (int d = 0; d < 4; d++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 2'(d), 1'b1);

        // Reset mid-run clears the high score too
        start_run();
        tick_cycles(3 * TPP);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        // Simultaneous events
        start_run();
        tick_cycles(2 * TPP + TPP - 1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);   // over with the point tick
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);   // start+over in OVER
        tick_cycles(TPP + 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);   // restart while running
        tick_cycles(TPP);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);   // start+over in RUNNING
        idle_cycle();

        // Random mix of all inputs with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic r, s, o, t;
            r = ($urandom_range(0, 499) != 0);
            s = ($urandom_range(0, 59) == 0);
            o = ($urandom_range(0, 79) == 0);
            t = ($urandom_range(0, 2) != 0);
            step(r, s, o, t, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #3;
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
